// File: rtl/sample_accumulator_16bit.sv
// Accumulates NUM_SAMPLES unsigned 16-bit samples through adder_16bit and
// presents the wrapped total with a sticky carry-out flag over a valid/ready pair.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);

    logic [15:0] gen;
    logic [15:0] prop;
    logic [3:0]  grp_gen;
    logic [3:0]  grp_prop;

    // Four 4-bit lookahead groups keep the carry chain short for the 10 ns cycle.
    always_comb begin
        gen  = a & b;
        prop = a ^ b;
        for (int k = 0; k < 4; k++) begin
            grp_gen[k]  = gen[4*k+3]
                        | (prop[4*k+3] & gen[4*k+2])
                        | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                        | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            grp_prop[k] = &prop[4*k +: 4];
        end
    end

    always_comb begin : carry_tree
        logic [4:0]  grp_carry;
        logic [15:0] bit_carry;
        grp_carry    = '0;
        bit_carry    = '0;
        grp_carry[0] = carry_in;
        for (int k = 0; k < 4; k++) begin
            grp_carry[k+1] = grp_gen[k] | (grp_prop[k] & grp_carry[k]);
        end
        for (int i = 0; i < 16; i++) begin
            if ((i % 4) == 0) begin
                bit_carry[i] = grp_carry[i / 4];
            end else begin
                bit_carry[i] = gen[i-1] | (prop[i-1] & bit_carry[i-1]);
            end
        end
        sum       = prop ^ bit_carry;
        carry_out = grp_carry[4];
    end

endmodule

// state  | meaning
// IDLE   | totals zeroed, waiting for the first sample
// ACCUM  | at least one sample taken, fewer than NUM_SAMPLES
// HOLD   | result presented, input stalled until out_ready
module sample_accumulator_16bit #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_sum,
    output logic        out_overflow,
    input  logic        out_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [7:0] SAMPLES_C = 8'(NUM_SAMPLES);

    logic [1:0]  state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [15:0] add_sum;
    logic        add_carry;
    logic [7:0]  cnt_inc;

    adder_16bit u_adder (
        .a         (acc_q),
        .b         (in_data),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    // in_ready is high in both states, so in_valid alone marks a transfer.
                    if (in_valid) begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_carry;
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == SAMPLES_C) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid    = (state_q == ST_HOLD);
    assign in_ready     = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign out_sum      = out_valid ? acc_q : 16'd0;
    assign out_overflow = out_valid & ovf_q;

endmodule

// File: tb/tb_sample_accumulator_16bit.sv
// Directed bench for sample_accumulator_16bit with NUM_SAMPLES = 4 and
// hand-computed totals.

module tb_sample_accumulator_16bit;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_sum;
    logic        out_overflow;
    logic        out_ready;

    int total;
    int bad;

    sample_accumulator_16bit #(.NUM_SAMPLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one sample, lets one edge pass, then samples just after it.
    task automatic xfer(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [15:0] s, input logic o);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".sum"}, {16'd0, out_sum}, {16'd0, s});
        chk({tag, ".ovf"}, {31'd0, out_overflow}, {31'd0, o});
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("accept.in_ready", {31'd0, in_ready}, 32'd1);
        chk("accept.valid", {31'd0, out_valid}, 32'd0);
        chk("accept.sum", {16'd0, out_sum}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'd0;
        out_ready = 1'b0;

        #2;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum", {16'd0, out_sum}, 32'd0);
        chk("rst.ovf", {31'd0, out_overflow}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic accumulation
        xfer(16'd1);
        xfer(16'd2);
        xfer(16'd3);
        chk("basic.early_valid", {31'd0, out_valid}, 32'd0);
        chk("basic.early_sum", {16'd0, out_sum}, 32'd0);
        xfer(16'd4);
        chk_result("basic", 16'd10, 1'b0);
        accept();

        // Overflow wrap cases
        xfer(16'd65535);
        xfer(16'd4);
        xfer(16'd0);
        xfer(16'd0);
        chk_result("ovf1", 16'd3, 1'b1);
        accept();
        xfer(16'd65534);
        xfer(16'd65533);
        xfer(16'd0);
        xfer(16'd0);
        chk_result("ovf2", 16'd65531, 1'b1);

        // Backpressure: held result, input ignored
        in_valid = 1'b1;
        in_data  = 16'd7;
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            chk_result("bp.hold", 16'd65531, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("bp.in_ready_after", {31'd0, in_ready}, 32'd1);
        chk("bp.valid_after", {31'd0, out_valid}, 32'd0);
        xfer(16'd3);
        xfer(16'd4);
        xfer(16'd0);
        xfer(16'd0);
        chk_result("bp.restart", 16'd7, 1'b0);
        accept();

        // Gapped input
        xfer(16'd8);
        idle_cycle();
        chk("gap.valid1", {31'd0, out_valid}, 32'd0);
        xfer(16'd65535);
        idle_cycle();
        idle_cycle();
        chk("gap.valid2", {31'd0, out_valid}, 32'd0);
        chk("gap.in_ready", {31'd0, in_ready}, 32'd1);
        xfer(16'd0);
        chk("gap.valid3", {31'd0, out_valid}, 32'd0);
        xfer(16'd0);
        chk_result("gap", 16'd7, 1'b1);
        accept();

        // Clear drops the concurrent sample and the partial total
        xfer(16'd100);
        xfer(16'd200);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd50;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr.in_ready", {31'd0, in_ready}, 32'd1);
        chk("clr.valid", {31'd0, out_valid}, 32'd0);
        xfer(16'd1);
        xfer(16'd1);
        xfer(16'd1);
        chk("clr.early_valid", {31'd0, out_valid}, 32'd0);
        xfer(16'd1);
        chk_result("clr", 16'd4, 1'b0);

        // Clear discards a pending result
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clrhold.valid", {31'd0, out_valid}, 32'd0);
        chk("clrhold.in_ready", {31'd0, in_ready}, 32'd1);

        // Asynchronous reset mid-HOLD, applied away from any edge
        xfer(16'd5);
        xfer(16'd5);
        xfer(16'd5);
        xfer(16'd5);
        chk_result("pre_rst", 16'd20, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", {31'd0, out_valid}, 32'd0);
        chk("arst.sum", {16'd0, out_sum}, 32'd0);
        chk("arst.ovf", {31'd0, out_overflow}, 32'd0);
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Asynchronous reset mid-ACCUM restarts the count
        xfer(16'd9);
        xfer(16'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_acc.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        xfer(16'd1);
        xfer(16'd2);
        xfer(16'd3);
        chk("post_rst.early_valid", {31'd0, out_valid}, 32'd0);
        xfer(16'd4);
        chk_result("post_rst", 16'd10, 1'b0);
        accept();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
